// File: rtl/cache_pkg.sv
// Shared types for the cache metadata array scheduler.
// Widths here size the update-buffer entry.
package cache_pkg;

  localparam int SET_IDX_W     = 4;
  localparam int META_W        = 1;
  localparam int UPD_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } meta_sched_state_e;

  typedef struct packed {
    logic [SET_IDX_W-1:0] addr;
    logic [META_W-1:0]    data;
  } upd_entry_t;

endpackage

// File: rtl/meta_array_sched_if.sv
// Lookup and update handshakes between a client
// and the metadata array scheduler.
interface meta_array_sched_if #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
);

  logic               lkp_valid;
  logic               lkp_ready;
  logic [S_INDEX-1:0] lkp_addr;
  logic               lkp_rvalid;
  logic [WIDTH-1:0]   lkp_rdata;
  logic               upd_valid;
  logic               upd_ready;
  logic [S_INDEX-1:0] upd_addr;
  logic [WIDTH-1:0]   upd_data;

  modport master (
    output lkp_valid, lkp_addr,
    output upd_valid, upd_addr, upd_data,
    input  lkp_ready, lkp_rvalid, lkp_rdata,
    input  upd_ready
  );

  modport slave (
    input  lkp_valid, lkp_addr,
    input  upd_valid, upd_addr, upd_data,
    output lkp_ready, lkp_rvalid, lkp_rdata,
    output upd_ready
  );

endinterface

// File: rtl/meta_upd_buf.sv
// Two-entry update FIFO; entry 0 is the head.
// Search returns the youngest entry matching an address.
module meta_upd_buf
  import cache_pkg::*;
(
  input  logic                 clk0,
  input  logic                 rst0_n,
  input  logic                 push,
  input  logic                 pop,
  input  upd_entry_t           push_entry,
  input  logic [SET_IDX_W-1:0] srch_addr,
  output upd_entry_t           head,
  output logic [1:0]           count,
  output logic                 hit,
  output logic [META_W-1:0]    hit_data
);

  upd_entry_t ent_q [UPD_BUF_DEPTH];
  logic [1:0] cnt_q;
  logic       wr_hi;

  assign wr_hi = (cnt_q - {1'b0, pop}) == 2'd1;
  assign head  = ent_q[0];
  assign count = cnt_q;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      cnt_q    <= '0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      if (pop) begin
        ent_q[0] <= ent_q[1];
      end
      if (push) begin
        if (wr_hi) ent_q[1] <= push_entry;
        else       ent_q[0] <= push_entry;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (cnt_q != 2'd0 && ent_q[0].addr == srch_addr) begin
      hit      = 1'b1;
      hit_data = ent_q[0].data;
    end
    // entry 1 is younger, so it overrides
    if (cnt_q == 2'd2 && ent_q[1].addr == srch_addr) begin
      hit      = 1'b1;
      hit_data = ent_q[1].data;
    end
  end

endmodule

// File: rtl/meta_array_sched.sv
// Port scheduler for the dual-port metadata flop array:
// lookups, buffered updates, flush sweep, RAW forwarding.
module meta_array_sched
  import cache_pkg::*;
#(
  parameter int S_INDEX = SET_IDX_W,
  parameter int WIDTH   = META_W
) (
  input  logic               clk0,
  input  logic               rst0_n,
  meta_array_sched_if.slave  bus,
  input  logic               flush_start,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               arr_csb0,
  output logic               arr_web0,
  output logic [S_INDEX-1:0] arr_addr0,
  input  logic [WIDTH-1:0]   arr_dout0,
  output logic               arr_csb1,
  output logic               arr_web1,
  output logic [S_INDEX-1:0] arr_addr1,
  output logic [WIDTH-1:0]   arr_din1
);

  meta_sched_state_e state_q, state_d;
  logic [S_INDEX:0]  fcnt_q, fcnt_d;

  logic       in_lkp_st, lkp_acc, upd_acc;
  logic       pop, flush_wr, upd_same;
  logic       buf_hit;
  logic [1:0] buf_cnt;
  upd_entry_t head, push_entry;
  logic [WIDTH-1:0] buf_data;

  logic             rvalid_q, fwd_q;
  logic [WIDTH-1:0] fwd_data_q;

  assign in_lkp_st = state_q == ST_IDLE
                  || state_q == ST_DRAIN;

  assign bus.lkp_ready = rst0_n && in_lkp_st;
  assign bus.upd_ready = rst0_n && state_q == ST_IDLE
                      && buf_cnt < 2'd2;

  assign lkp_acc = bus.lkp_valid && bus.lkp_ready;
  assign upd_acc = bus.upd_valid && bus.upd_ready;

  assign pop      = rst0_n && in_lkp_st && buf_cnt != 2'd0;
  assign flush_wr = rst0_n && state_q == ST_FLUSH;
  assign upd_same = upd_acc && bus.upd_addr == bus.lkp_addr;

  assign push_entry = '{addr: bus.upd_addr, data: bus.upd_data};

  meta_upd_buf u_buf (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .push       (upd_acc),
    .pop        (pop),
    .push_entry (push_entry),
    .srch_addr  (bus.lkp_addr),
    .head       (head),
    .count      (buf_cnt),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );

  assign arr_csb0  = !lkp_acc;
  assign arr_web0  = 1'b1;
  assign arr_addr0 = lkp_acc ? bus.lkp_addr : '0;
  assign arr_csb1  = !(pop || flush_wr);
  assign arr_web1  = 1'b0;

  always_comb begin
    arr_addr1 = '0;
    arr_din1  = '0;
    unique case (1'b1)
      flush_wr: arr_addr1 = fcnt_q[S_INDEX-1:0];
      pop: begin
        arr_addr1 = head.addr;
        arr_din1  = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_start) begin
          state_d = (buf_cnt != 2'd0 || upd_acc)
                  ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (buf_cnt == 2'd0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // carry into the top bit marks the last set
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_d[S_INDEX]) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rvalid_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rvalid_q <= lkp_acc;
      if (lkp_acc) begin
        fwd_q      <= upd_same || buf_hit;
        fwd_data_q <= upd_same ? bus.upd_data : buf_data;
      end
    end
  end

  assign bus.lkp_rvalid = rvalid_q;
  assign bus.lkp_rdata  = !rvalid_q ? '0
                        : fwd_q ? fwd_data_q : arr_dout0;

  assign flush_busy = state_q != ST_IDLE;
  assign flush_done = state_q == ST_DONE;

endmodule

// File: tb/tb_meta_array_sched.sv
// Scoreboard bench for meta_array_sched with a
// behavioural model of the dual-port flop array.
module tb_meta_array_sched;

  logic       clk0 = 1'b0;
  logic       rst0_n;
  logic       flush_start;
  logic       flush_busy, flush_done;
  logic       arr_csb0, arr_web0, arr_csb1, arr_web1;
  logic [3:0] arr_addr0, arr_addr1;
  logic [0:0] arr_dout0, arr_din1;

  meta_array_sched_if #(.S_INDEX(4), .WIDTH(1)) bus ();

  meta_array_sched #(.S_INDEX(4), .WIDTH(1)) dut (
    .clk0        (clk0),
    .rst0_n      (rst0_n),
    .bus         (bus),
    .flush_start (flush_start),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .arr_csb0    (arr_csb0),
    .arr_web0    (arr_web0),
    .arr_addr0   (arr_addr0),
    .arr_dout0   (arr_dout0),
    .arr_csb1    (arr_csb1),
    .arr_web1    (arr_web1),
    .arr_addr1   (arr_addr1),
    .arr_din1    (arr_din1)
  );

  always #5 clk0 = ~clk0;

  // array: read data after the sampling edge, write one edge later
  bit [0:0] mem [16];
  bit       pend_v;
  bit [3:0] pend_a;
  bit [0:0] pend_d;

  always @(posedge clk0) begin
    if (pend_v) mem[pend_a] = pend_d;
    if (!arr_csb0) arr_dout0 <= mem[arr_addr0];
    pend_v <= !arr_csb1 && !arr_web1;
    pend_a <= arr_addr1;
    pend_d <= arr_din1;
  end

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_rd_q [$];
  logic [4:0] exp_wr_q [$];

  initial begin
    logic [0:0] er;
    logic [4:0] ew;
    forever begin
      @(negedge clk0);
      if (bus.lkp_rvalid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL lkp_resp unexpected rdata=%0d",
                   bus.lkp_rdata);
        end else begin
          er = exp_rd_q.pop_front();
          if (bus.lkp_rdata !== er) begin
            errors++;
            $display("FAIL lkp_resp got %0d want %0d",
                     bus.lkp_rdata, er);
          end
        end
      end
      if (rst0_n && !arr_csb1) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL arr_wr unexpected a=%0d d=%0d",
                   arr_addr1, arr_din1);
        end else begin
          ew = exp_wr_q.pop_front();
          if ({arr_addr1, arr_din1} !== ew) begin
            errors++;
            $display("FAIL arr_wr got a=%0d d=%0d want a=%0d d=%0d",
                     arr_addr1, arr_din1, ew[4:1], ew[0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.lkp_valid = 1'b0;
    bus.upd_valid = 1'b0;
    flush_start   = 1'b0;
  endtask

  task automatic lkp(logic [3:0] a, logic [0:0] e);
    bus.lkp_valid = 1'b1;
    bus.lkp_addr  = a;
    exp_rd_q.push_back(e);
  endtask

  task automatic upd(logic [3:0] a, logic [0:0] d);
    bus.upd_valid = 1'b1;
    bus.upd_addr  = a;
    bus.upd_data  = d;
    exp_wr_q.push_back({a, d});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int busy_n;
    int done_n;
    bit left;
    rst0_n        = 1'b0;
    bus.lkp_valid = 1'b1;
    bus.lkp_addr  = 4'd3;
    bus.upd_valid = 1'b1;
    bus.upd_addr  = 4'd3;
    bus.upd_data  = 1'b1;
    flush_start   = 1'b1;
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    chk("rst_lkp_ready", bus.lkp_ready, 0);
    chk("rst_upd_ready", bus.upd_ready, 0);
    chk("rst_csb0", arr_csb0, 1);
    chk("rst_csb1", arr_csb1, 1);
    chk("rst_busy", flush_busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_rvalid", bus.lkp_rvalid, 0);
    chk("rst_addr", {arr_addr0, arr_addr1, arr_din1}, 0);
    idle_in();
    step();
    rst0_n = 1'b1;
    @(negedge clk0);
    chk("rel_lkp_ready", bus.lkp_ready, 1);
    chk("rel_upd_ready", bus.upd_ready, 1);

    // forwarding from the issuing head, then from the array
    step();
    upd(4'd3, 1'b1);
    step();
    idle_in();
    lkp(4'd3, 1'b1);
    step();
    idle_in();
    step();
    lkp(4'd3, 1'b1);
    step();
    idle_in();

    // same-cycle lookup and update
    lkp(4'd5, 1'b1);
    upd(4'd5, 1'b1);
    step();
    idle_in();
    repeat (3) step();
    lkp(4'd5, 1'b1);
    step();
    lkp(4'd7, 1'b0);
    step();
    idle_in();

    // back-to-back updates
    upd(4'd1, 1'b1);
    step();
    upd(4'd2, 1'b1);
    step();
    upd(4'd6, 1'b1);
    @(negedge clk0);
    chk("burst_upd_ready", bus.upd_ready, 1);
    step();
    idle_in();
    repeat (4) step();
    lkp(4'd1, 1'b1);
    step();
    lkp(4'd6, 1'b1);
    step();
    lkp(4'd2, 1'b1);
    step();
    idle_in();
    step();

    // flush with updates in flight
    upd(4'd8, 1'b1);
    step();
    upd(4'd9, 1'b1);
    flush_start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_wr_q.push_back({i[3:0], 1'b0});
    end
    @(negedge clk0);
    chk("fl_busy_idle", flush_busy, 0);
    step();
    idle_in();
    lkp(4'd9, 1'b1);
    @(negedge clk0);
    chk("fl_busy_drain", flush_busy, 1);
    chk("fl_upd_ready_drain", bus.upd_ready, 0);
    chk("fl_lkp_ready_drain", bus.lkp_ready, 1);
    step();
    lkp(4'd8, 1'b1);
    step();
    idle_in();
    busy_n = 0;
    done_n = 0;
    left   = 1'b0;
    for (int i = 0; i < 40 && !left; i++) begin
      @(negedge clk0);
      if (i == 1) chk("fl_lkp_ready_flush", bus.lkp_ready, 0);
      if (flush_busy) busy_n++;
      if (flush_done) done_n++;
      if (!flush_busy) left = 1'b1;
      else step();
    end
    chk("fl_finished", left, 1);
    chk("fl_busy_cycles", busy_n, 17);
    chk("fl_done_pulses", done_n, 1);
    step();
    lkp(4'd9, 1'b0);
    step();
    lkp(4'd3, 1'b0);
    step();
    lkp(4'd15, 1'b0);
    step();
    idle_in();
    step();

    // reset in the middle of the sweep
    flush_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_wr_q.push_back({i[3:0], 1'b0});
    end
    step();
    flush_start = 1'b0;
    repeat (5) step();
    rst0_n = 1'b0;
    @(negedge clk0);
    chk("mid_rst_busy", flush_busy, 0);
    chk("mid_rst_done", flush_done, 0);
    chk("mid_rst_csb1", arr_csb1, 1);
    step();
    step();
    rst0_n = 1'b1;
    done_n = 0;
    @(negedge clk0);
    chk("mid_rel_lkp_ready", bus.lkp_ready, 1);
    chk("mid_rel_upd_ready", bus.upd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk0);
      if (flush_done || flush_busy) done_n++;
      step();
    end
    chk("mid_no_done", done_n, 0);

    repeat (3) step();
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("wr_queue_empty", exp_wr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
